display_arbiter: RTL and testbench
==================================

# display_arbiter

Shares the four-digit seven-segment display between three requesters: alert/error (0), calculator result (1) and keypad entry (2). The block sits directly upstream of the display multiplexer and drives its 16-bit value and 4-bit decimal-point inputs. Requester 0 has fixed pre-emptive priority. Requesters 1 and 2 alternate round-robin. Every owner keeps the display for a minimum hold time, so a value is never shown for less than a full scan.

## Interface
- HOLD_CYCLES, 1024: minimum clk cycles an owner keeps the display, legal range 1..65535. The default equals one full 4-digit scan at 256 clocks per digit.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  3  request per source, level-sensitive; bit i asserted means source i wants the display
- val0, val1, val2  in  16 each  4-digit hex value from source i
- pt0, pt1, pt2  in  4 each  decimal-point mask from source i (bit n = digit n point on)
- grant  out  3  one-hot (or zero) current owner, registered
- disp_value  out  16  value to display multiplexer, registered
- disp_point  out  4  point mask to display multiplexer, registered
- busy  out  1  high in SHOW or LINGER, registered

## Operation
- State machine: IDLE, SHOW, LINGER. Internal registers:
  - owner (2 bits)
  - hold_cnt (16 bits, saturating at HOLD_CYCLES)
  - rr_last (which of 1/2 was last granted; reset value = 2, so 1 wins first)
- Arbitration function pick(req):
  - req[0] → 0.
  - Else if req[1] and req[2] → whichever of 1 or 2 is not rr_last.
  - Else the single requester of 1 or 2.
  - Else none.
- IDLE:
  - grant = 0.
  - disp_value and disp_point hold their last contents.
  - If pick ≠ none: owner ← pick, grant ← onehot(pick), hold_cnt ← 1, capture val/pt of pick, go to SHOW.
  - If pick is 1 or 2, rr_last ← pick.
- SHOW:
  - disp_value and disp_point track the owner's val and pt every cycle (live update).
  - hold_cnt increments, saturating.
  - If the owner's req drops: when hold_cnt ≥ HOLD_CYCLES, re-arbitrate immediately. Re-arbitration means grant pick and return to SHOW, or go to IDLE if there is no request. Otherwise go to LINGER.
- LINGER:
  - Owner keeps grant; the display is frozen at the last captured value; hold_cnt keeps counting.
  - If the owner's req re-asserts, return to SHOW with hold_cnt not reset.
  - When hold_cnt ≥ HOLD_CYCLES, re-arbitrate as above.
- Pre-emption: in SHOW or LINGER with owner 1 or 2, req[0] forces an immediate handover to 0, regardless of hold_cnt. rr_last is unchanged.
- Owner 0 is never pre-empted.
- Handover is gapless: the old grant bit falls and the new one rises on the same edge. grant is never multi-hot.
- The owner's own request remaining high does not yield to waiting sources. Sources 1 and 2 must drop req to share.

## Timing
- Reset values: grant = 000, disp_value = 0x0000, disp_point = 0000, busy = 0, state = IDLE, hold_cnt = 0, rr_last = 2.
- Reset mid-operation: all outputs return to their reset values asynchronously. The first grant is possible on the first clk edge after rst deasserts.
- Latency:
  - req sampled at edge k → grant, busy and disp_value valid after edge k.
  - A val change while in SHOW appears on disp_value one edge later.
- Minimum ownership: a non-pre-empted owner holds grant for at least HOLD_CYCLES edges. With HOLD_CYCLES = 1, a req drop releases on the next edge.
- hold_cnt saturates at HOLD_CYCLES and never wraps.
- Simultaneous events:
  - Owner drop and req[0] rise on the same edge → 0 is granted immediately.
  - req[1] and req[2] rise together from IDLE after reset → 1 is granted.

## Test plan
- Reset, then req = 010, val1 = 0x1234, pt1 = 0100 → grant = 010, disp_value = 0x1234, disp_point = 0100 after one edge; change val1 to 0xBEEF → disp_value = 0xBEEF next edge.
- HOLD_CYCLES = 8:
  - Grant source 2, drop req[2] after 2 cycles → LINGER, display frozen, grant = 100 for 8 edges total, then 000 with busy = 0.
  - Re-assert req[2] mid-LINGER → live tracking resumes with no extra hold.
- Source 1 owns in SHOW; raise req[0] with val0 = 0xE000 → next edge grant = 001, disp_value = 0xE000; source 0 is not pre-empted by any later req.
- req = 110 held, each owner drops after hold expiry and re-raises → grants alternate 010, 100, 010; grant is never 110.
- Assert rst during LINGER → grant = 000, disp_value = 0, busy = 0 immediately, without waiting for a clk edge.
- Owner drop coincides with hold_cnt = HOLD_CYCLES and req[2] high → grant moves 010 → 100 on one edge with no idle cycle.

Source files
------------

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - three-source seven-segment display arbiter with minimum hold time
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [3:0]  pt0,
    input  logic [3:0]  pt1,
    input  logic [3:0]  pt2,
    output logic [2:0]  grant,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_point,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

    localparam logic [15:0] HOLD = 16'(HOLD_CYCLES);

    state_t      state, state_n;
    logic [1:0]  owner, owner_n;
    logic [15:0] hold_cnt, hold_n;
    logic [1:0]  rr_last, rr_n;
    logic [2:0]  grant_n;
    logic [15:0] value_n;
    logic [3:0]  point_n;
    logic        busy_n;

    logic        pick_valid;
    logic [1:0]  pick_id;
    logic [15:0] pick_val, own_val;
    logic [3:0]  pick_pt, own_pt;
    logic        owner_req;
    logic        hold_done;
    logic [15:0] hold_inc;
    logic        do_arb;

    // Source 0 always wins; 1 and 2 alternate when both ask.
    always_comb begin
        pick_valid = 1'b1;
        pick_id    = 2'd0;
        if (req[0])
            pick_id = 2'd0;
        else if (req[1] && req[2])
            pick_id = (rr_last == 2'd1) ? 2'd2 : 2'd1;
        else if (req[1])
            pick_id = 2'd1;
        else if (req[2])
            pick_id = 2'd2;
        else
            pick_valid = 1'b0;
    end

    always_comb begin
        case (pick_id)
            2'd1:    begin pick_val = val1; pick_pt = pt1; end
            2'd2:    begin pick_val = val2; pick_pt = pt2; end
            default: begin pick_val = val0; pick_pt = pt0; end
        endcase
        case (owner)
            2'd1:    begin own_val = val1; own_pt = pt1; owner_req = req[1]; end
            2'd2:    begin own_val = val2; own_pt = pt2; owner_req = req[2]; end
            default: begin own_val = val0; own_pt = pt0; owner_req = req[0]; end
        endcase
    end

    assign hold_done = (hold_cnt >= HOLD);
    assign hold_inc  = hold_done ? HOLD : 16'(hold_cnt + 16'd1);

    always_comb begin
        state_n = state;
        owner_n = owner;
        hold_n  = hold_cnt;
        rr_n    = rr_last;
        grant_n = grant;
        value_n = disp_value;
        point_n = disp_point;
        busy_n  = busy;
        do_arb  = 1'b0;

        case (state)
            IDLE: do_arb = 1'b1;
            SHOW, LINGER: begin
                hold_n = hold_inc;
                if (owner != 2'd0 && req[0]) begin
                    // Alerts pre-empt immediately; the round-robin pointer is untouched.
                    state_n = SHOW;
                    owner_n = 2'd0;
                    grant_n = 3'b001;
                    hold_n  = 16'd1;
                    value_n = val0;
                    point_n = pt0;
                    busy_n  = 1'b1;
                end else if (owner_req) begin
                    state_n = SHOW;
                    value_n = own_val;
                    point_n = own_pt;
                end else if (hold_done) begin
                    do_arb = 1'b1;
                end else begin
                    state_n = LINGER;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_arb) begin
            if (pick_valid) begin
                state_n = SHOW;
                owner_n = pick_id;
                grant_n = 3'b001 << pick_id;
                hold_n  = 16'd1;
                value_n = pick_val;
                point_n = pick_pt;
                busy_n  = 1'b1;
                if (pick_id != 2'd0)
                    rr_n = pick_id;
            end else begin
                state_n = IDLE;
                grant_n = 3'b000;
                hold_n  = 16'd0;
                busy_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            hold_cnt   <= 16'd0;
            rr_last    <= 2'd2;
            grant      <= 3'b000;
            disp_value <= 16'h0000;
            disp_point <= 4'b0000;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            hold_cnt   <= hold_n;
            rr_last    <= rr_n;
            grant      <= grant_n;
            disp_value <= value_n;
            disp_point <= point_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed and randomized checks of display_arbiter against a reference model
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [15:0] val0 = 16'h0, val1 = 16'h0, val2 = 16'h0;
    logic [3:0]  pt0 = 4'h0, pt1 = 4'h0, pt2 = 4'h0;

    logic [2:0]  grant, grant_h1;
    logic [15:0] disp_value, disp_value_h1;
    logic [3:0]  disp_point, disp_point_h1;
    logic        busy, busy_h1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display_arbiter #(.HOLD_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .pt0(pt0), .pt1(pt1), .pt2(pt2),
        .grant(grant), .disp_value(disp_value), .disp_point(disp_point), .busy(busy)
    );

    display_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst(rst), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .pt0(pt0), .pt1(pt1), .pt2(pt2),
        .grant(grant_h1), .disp_value(disp_value_h1), .disp_point(disp_point_h1), .busy(busy_h1)
    );

    // Reference model: owner (-1 = nobody), age = edges since the grant edge.
    int          m_owner[2];
    int          m_age[2];
    int          m_rr[2];
    logic [15:0] m_dv[2];
    logic [3:0]  m_dp[2];

    function automatic logic [15:0] src_val(int i);
        return (i == 0) ? val0 : (i == 1) ? val1 : val2;
    endfunction

    function automatic logic [3:0] src_pt(int i);
        return (i == 0) ? pt0 : (i == 1) ? pt1 : pt2;
    endfunction

    function automatic int m_pick(int k);
        if (req[0]) return 0;
        if (req[1] && req[2]) return (m_rr[k] == 1) ? 2 : 1;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return -1;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_age[k] = 0; m_rr[k] = 2; m_dv[k] = 16'h0; m_dp[k] = 4'h0;
        end
    endtask

    task automatic m_give(int k, int p, bit rr_upd);
        m_owner[k] = p;
        m_age[k]   = 1;
        m_dv[k]    = src_val(p);
        m_dp[k]    = src_pt(p);
        if (rr_upd && p != 0) m_rr[k] = p;
    endtask

    task automatic m_step(int k, int hold);
        int p, o;
        p = m_pick(k);
        o = m_owner[k];
        if (o < 0) begin
            if (p >= 0) m_give(k, p, 1'b1);
        end else if (o != 0 && req[0]) begin
            m_give(k, 0, 1'b0);
        end else if (req[o]) begin
            m_dv[k] = src_val(o);
            m_dp[k] = src_pt(o);
            m_age[k]++;
        end else if (m_age[k] >= hold) begin
            if (p >= 0) m_give(k, p, 1'b1);
            else m_owner[k] = -1;
        end else begin
            m_age[k]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 3'b000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant got %b want 000", grant); end
        n_checks++; if (disp_value !== 16'h0) begin n_fail++; $display("FAIL reset_value got %h want 0000", disp_value); end
        n_checks++; if (disp_point !== 4'h0) begin n_fail++; $display("FAIL reset_point got %b want 0000", disp_point); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (grant_h1 !== 3'b000 || busy_h1 !== 1'b0) begin n_fail++; $display("FAIL reset_h1 got grant %b busy %b want 000 0", grant_h1, busy_h1); end
    endtask

    task automatic test_basic();
        do_reset();
        req = 3'b010; val1 = 16'h1234; pt1 = 4'b0100;
        step();
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL basic_grant got %b want 010", grant); end
        n_checks++; if (disp_value !== 16'h1234) begin n_fail++; $display("FAIL basic_value got %h want 1234", disp_value); end
        n_checks++; if (disp_point !== 4'b0100) begin n_fail++; $display("FAIL basic_point got %b want 0100", disp_point); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        val1 = 16'hBEEF;
        step();
        n_checks++; if (disp_value !== 16'hBEEF) begin n_fail++; $display("FAIL basic_live got %h want beef", disp_value); end
    endtask

    task automatic test_linger();
        do_reset();
        req = 3'b100; val2 = 16'h2222; pt2 = 4'b0001;
        step();
        step();
        req = 3'b000; val2 = 16'h5555;
        for (int e = 2; e < 8; e++) begin
            step();
            n_checks++; if (grant !== 3'b100 || disp_value !== 16'h2222) begin n_fail++; $display("FAIL linger_hold edge %0d got %b %h want 100 2222", e, grant, disp_value); end
        end
        step();
        n_checks++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL linger_release got %b busy %b want 000 0", grant, busy); end
        n_checks++; if (disp_value !== 16'h2222) begin n_fail++; $display("FAIL linger_idle_value got %h want 2222", disp_value); end

        do_reset();
        req = 3'b100; val2 = 16'h3333;
        step();
        req = 3'b000;
        step();
        step();
        req = 3'b100; val2 = 16'h4444;
        step();
        val2 = 16'h4545;
        step();
        n_checks++; if (disp_value !== 16'h4545) begin n_fail++; $display("FAIL reassert_live got %h want 4545", disp_value); end
        step();
        req = 3'b000;
        step();
        step();
        n_checks++; if (grant !== 3'b100) begin n_fail++; $display("FAIL reassert_hold got %b want 100", grant); end
        step();
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reassert_no_extra_hold got %b want 000", grant); end
    endtask

    task automatic test_preempt();
        do_reset();
        req = 3'b010; val1 = 16'h1111;
        step();
        step();
        req = 3'b011; val0 = 16'hE000; pt0 = 4'b1000;
        step();
        n_checks++; if (grant !== 3'b001 || disp_value !== 16'hE000) begin n_fail++; $display("FAIL preempt got %b %h want 001 e000", grant, disp_value); end
        n_checks++; if (disp_point !== 4'b1000) begin n_fail++; $display("FAIL preempt_point got %b want 1000", disp_point); end
        req = 3'b111;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL owner0_kept cycle %0d got %b want 001", i, grant); end
        end

        do_reset();
        req = 3'b100;
        step();
        req = 3'b001;
        step();
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL drop_with_alert got %b want 001", grant); end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        do_reset();
        req = 3'b110;
        step();
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rr_first got %b want 010", grant); end
        want = 3'b010;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 9; i++) begin
                step();
                n_checks++; if (grant !== want) begin n_fail++; $display("FAIL rr_keep round %0d got %b want %b", r, grant, want); end
            end
            req  = (want == 3'b010) ? 3'b100 : 3'b010;
            want = req;
            step();
            n_checks++; if (grant !== want) begin n_fail++; $display("FAIL rr_handover round %0d got %b want %b", r, grant, want); end
            req = 3'b110;
        end

        do_reset();
        req = 3'b010;
        for (int i = 0; i < 9; i++) step();
        req = 3'b000;
        step();
        req = 3'b110;
        step();
        n_checks++; if (grant !== 3'b100) begin n_fail++; $display("FAIL rr_turn got %b want 100", grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b100; val2 = 16'h7777;
        step();
        req = 3'b000;
        step();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (grant !== 3'b000 || disp_value !== 16'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset got %b %h %b want 000 0000 0", grant, disp_value, busy); end
        #1 rst = 1'b0;
        req = 3'b010; val1 = 16'h0A0A;
        step();
        n_checks++; if (grant !== 3'b010 || disp_value !== 16'h0A0A) begin n_fail++; $display("FAIL first_after_reset got %b %h want 010 0a0a", grant, disp_value); end
    endtask

    task automatic test_random();
        logic [2:0]  a_g[2];
        logic [15:0] a_v[2];
        logic [3:0]  a_p[2];
        logic        a_b[2];
        logic [2:0]  e_g;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (req[0]) begin if ($urandom_range(3) == 0) req[0] = 1'b0; end
            else if ($urandom_range(15) == 0) req[0] = 1'b1;
            if ($urandom_range(5) == 0) req[1] = ~req[1];
            if ($urandom_range(5) == 0) req[2] = ~req[2];
            if ($urandom_range(3) == 0) begin val0 = 16'($urandom); pt0 = 4'($urandom); end
            if ($urandom_range(3) == 0) begin val1 = 16'($urandom); pt1 = 4'($urandom); end
            if ($urandom_range(3) == 0) begin val2 = 16'($urandom); pt2 = 4'($urandom); end
            m_step(0, 8);
            m_step(1, 1);
            step();
            a_g[0] = grant;    a_v[0] = disp_value;    a_p[0] = disp_point;    a_b[0] = busy;
            a_g[1] = grant_h1; a_v[1] = disp_value_h1; a_p[1] = disp_point_h1; a_b[1] = busy_h1;
            for (int k = 0; k < 2; k++) begin
                e_g = (m_owner[k] < 0) ? 3'b000 : 3'(1 << m_owner[k]);
                n_checks++; if (a_g[k] !== e_g) begin n_fail++; $display("FAIL rand_grant dut%0d cycle %0d got %b want %b", k, c, a_g[k], e_g); end
                n_checks++; if (a_v[k] !== m_dv[k]) begin n_fail++; $display("FAIL rand_value dut%0d cycle %0d got %h want %h", k, c, a_v[k], m_dv[k]); end
                n_checks++; if (a_p[k] !== m_dp[k]) begin n_fail++; $display("FAIL rand_point dut%0d cycle %0d got %b want %b", k, c, a_p[k], m_dp[k]); end
                n_checks++; if (a_b[k] !== (m_owner[k] >= 0)) begin n_fail++; $display("FAIL rand_busy dut%0d cycle %0d got %b want %b", k, c, a_b[k], m_owner[k] >= 0); end
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_linger();
        test_preempt();
        test_round_robin();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
